// File: rtl/hive_pkg.sv
// Shared definitions for the hive erosion engine: hive geometry, RAM
// write-control encodings, the engine state type and a saturating counter helper.
package hive_pkg;

  localparam int HIVE_W  = 66;
  localparam int HIVE_H  = 39;
  localparam int HIVE_AW = 12;

  // Colour index that marks an empty (transparent) hive pixel
  localparam logic [7:0] BG_IDX = 8'h00;

  // RAM write-control encodings (ram_write port)
  localparam logic [1:0] HIVE_RD = 2'd0;
  localparam logic [1:0] HIVE_WR = 2'd1;

  // Engine states
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD,
    CHK,
    WR,
    NEXT,
    DONE
  } dmg_state_t;

  // Count up by one, sticking at the 6-bit maximum
  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/hive_cell_walker.sv
// Crater window walker: holds the signed window origin and the (cx, cy)
// scan position, and derives the current cell's RAM address plus a skip flag
// for cells that fall off the hive or are masked.
// Optional feature: HIVE_DAMAGE_RAGGED_EN masks the four window corners.
module hive_cell_walker
  import hive_pkg::*;
#(
  parameter int CRATER_W = 3,
  parameter int CRATER_H = 3
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic               start,
  input  logic               advance,
  input  logic [6:0]         hit_x,
  input  logic [5:0]         hit_y,
  output logic [HIVE_AW-1:0] cell_addr,
  output logic               skip,
  output logic               last
);

  localparam logic signed [7:0] HALF_W  = 8'((CRATER_W - 1) / 2);
  localparam logic signed [6:0] HALF_H  = 7'((CRATER_H - 1) / 2);
  localparam logic [2:0]        CX_LAST = 3'(CRATER_W - 1);
  localparam logic [2:0]        CY_LAST = 3'(CRATER_H - 1);
  localparam logic signed [7:0] X_MAX   = 8'(HIVE_W - 1);
  localparam logic signed [6:0] Y_MAX   = 7'(HIVE_H - 1);

  // Origin can go negative near the left/top edge, hence signed.
  // x range -3..71 fits 8 signed bits, y range -3..44 fits 7 signed bits.
  logic signed [7:0]  org_x_reg;
  logic signed [6:0]  org_y_reg;
  logic [2:0]         cx_reg;
  logic [2:0]         cy_reg;

  logic signed [7:0]  cell_x;
  logic signed [6:0]  cell_y;
  logic               clip;
  logic               mask;
  logic [HIVE_AW-1:0] x_ext;
  logic [HIVE_AW-1:0] y_ext;

  // Latch the window origin on start, then step cx fastest and cy second
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      org_x_reg <= '0;
      org_y_reg <= '0;
      cx_reg    <= '0;
      cy_reg    <= '0;
    end else if (start) begin
      org_x_reg <= $signed({1'b0, hit_x}) - HALF_W;
      org_y_reg <= $signed({1'b0, hit_y}) - HALF_H;
      cx_reg    <= '0;
      cy_reg    <= '0;
    end else if (advance) begin
      if (cx_reg == CX_LAST) begin
        cx_reg <= '0;
        cy_reg <= cy_reg + 3'd1;
      end else begin
        cx_reg <= cx_reg + 3'd1;
      end
    end
  end

  // Current cell position in hive coordinates
  assign cell_x = org_x_reg + $signed({5'b0, cx_reg});
  assign cell_y = org_y_reg + $signed({4'b0, cy_reg});

  // Off-hive cells: negative (sign bit) or beyond the last column/row
  assign clip = cell_x[7] | (cell_x > X_MAX) | cell_y[6] | (cell_y > Y_MAX);

`ifdef HIVE_DAMAGE_RAGGED_EN
  // Knock out the four corners for a rounded crater outline
  assign mask = ((cx_reg == 3'd0) || (cx_reg == CX_LAST)) &&
                ((cy_reg == 3'd0) || (cy_reg == CY_LAST));
`else
  assign mask = 1'b0;
`endif

  assign skip = clip | mask;
  assign last = (cx_reg == CX_LAST) && (cy_reg == CY_LAST);

  // Row-major linear address; only meaningful when clip is low, where
  // y*66+x <= 2573 and fits the 12-bit address without truncation
  assign x_ext     = {5'b0, cell_x[6:0]};
  assign y_ext     = {6'b0, cell_y[5:0]};
  assign cell_addr = y_ext * 12'(HIVE_W) + x_ext;

endmodule

// File: rtl/hive_damage.sv
// Bullet-impact erosion engine in front of the single-port hive RAM.
// Walks a crater window around the impact pixel during blanking, erases
// solid pixels to the background index and reports how many it erased.
// During active video the renderer's address passes straight to the RAM.
// Optional feature: HIVE_DAMAGE_RAGGED_EN (corner-masked crater, in walker).
module hive_damage
  import hive_pkg::*;
#(
  parameter int CRATER_W = 3,
  parameter int CRATER_H = 3
) (
  input  logic                clk_pix,
  input  logic                rst_n,
  input  logic                blank,
  input  logic [HIVE_AW-1:0]  disp_addr,
  input  logic                hit_req,
  input  logic [6:0]          hit_x,
  input  logic [5:0]          hit_y,
  output logic [HIVE_AW-1:0]  ram_addr,
  output logic [1:0]          ram_write,
  output logic [7:0]          ram_data,
  input  logic [7:0]          ram_dout,
  output logic                busy,
  output logic                done,
  output logic [5:0]          solid_cnt
);

  dmg_state_t         state_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [5:0]         cnt_reg;
  logic [5:0]         solid_cnt_reg;

  logic               walk_start;
  logic               walk_advance;
  logic [HIVE_AW-1:0] cell_addr;
  logic               cell_skip;
  logic               cell_last;
  logic               eng_owns_ram;

  // A new crater is accepted only from IDLE; requests while busy are dropped
  assign walk_start   = (state_reg == IDLE) && hit_req;
  assign walk_advance = (state_reg == NEXT) && !cell_last;

  hive_cell_walker #(
    .CRATER_W (CRATER_W),
    .CRATER_H (CRATER_H)
  ) u_walker (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .start     (walk_start),
    .advance   (walk_advance),
    .hit_x     (hit_x),
    .hit_y     (hit_y),
    .cell_addr (cell_addr),
    .skip      (cell_skip),
    .last      (cell_last)
  );

  // Crater sequencing: read each legal cell, erase it if solid, pulse done at the end.
  // Losing blank in any RAM-touching state parks in WAIT with the cell retained,
  // so the read is reissued on resume and a stale ram_dout is never trusted.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cnt_reg       <= '0;
      solid_cnt_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (hit_req) begin
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (blank) state_reg <= RD;
        end
        RD: begin
          if (!blank)         state_reg <= WAIT;
          else if (cell_skip) state_reg <= NEXT;
          else                state_reg <= CHK;
        end
        CHK: begin
          if (!blank)                  state_reg <= WAIT;
          else if (ram_dout != BG_IDX) state_reg <= WR;
          else                         state_reg <= NEXT;
        end
        WR: begin
          if (!blank) begin
            state_reg <= WAIT;
          end else begin
            cnt_reg   <= sat_inc6(cnt_reg);
            state_reg <= NEXT;
          end
        end
        NEXT: begin
          if (cell_last) begin
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            solid_cnt_reg <= cnt_reg;
            state_reg     <= DONE;
          end else begin
            state_reg <= RD;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // RAM mux: engine drives the port only in a live access state during blanking
  always_comb begin
    eng_owns_ram = 1'b0;
    if (blank) begin
      eng_owns_ram = ((state_reg == RD) && !cell_skip) ||
                     (state_reg == CHK) || (state_reg == WR);
    end
    ram_addr  = eng_owns_ram ? cell_addr : disp_addr;
    ram_write = (eng_owns_ram && (state_reg == WR)) ? HIVE_WR : HIVE_RD;
  end

  assign ram_data  = BG_IDX;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign solid_cnt = solid_cnt_reg;

endmodule

// File: tb/tb_hive_damage.sv
// Scoreboard bench for hive_damage: stimulus pushes expected RAM writes and
// crater results into queues, a negedge monitor pops and compares them.
module tb_hive_damage;
  import hive_pkg::*;

  typedef struct {
    int cnt;
    int lat;
  } exp_done_t;

  logic        clk_pix = 1'b0;
  logic        rst_n   = 1'b0;
  logic        blank   = 1'b1;
  logic [11:0] disp_addr = 12'd0;
  logic        hit_req = 1'b0;
  logic [6:0]  hit_x   = 7'd0;
  logic [5:0]  hit_y   = 6'd0;
  logic [11:0] ram_addr;
  logic [1:0]  ram_write;
  logic [7:0]  ram_data;
  logic [7:0]  ram_dout;
  logic        busy;
  logic        done;
  logic [5:0]  solid_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_hit_cyc = 0;
  int done_cnt = 0;
  int cnt1999 = 0;
  int ea;
  exp_done_t ed;

  int        exp_wr_q[$];
  exp_done_t exp_done_q[$];
  int        wtab[$];

`ifdef HIVE_DAMAGE_RAGGED_EN
  localparam int RAGGED = 1;
`else
  localparam int RAGGED = 0;
`endif

  hive_damage dut (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .blank     (blank),
    .disp_addr (disp_addr),
    .hit_req   (hit_req),
    .hit_x     (hit_x),
    .hit_y     (hit_y),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_data  (ram_data),
    .ram_dout  (ram_dout),
    .busy      (busy),
    .done      (done),
    .solid_cnt (solid_cnt)
  );

  always #20 clk_pix = ~clk_pix;

  always @(posedge clk_pix) cyc <= cyc + 1;

  // Hive RAM model: solid 5A everywhere except five background pixels at (10,10)
  logic [7:0] mem [0:4095];
  logic mem_ready = 1'b0;
  always @(posedge clk_pix) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h5A;
      mem[603] <= 8'h00;
      mem[605] <= 8'h00;
      mem[670] <= 8'h00;
      mem[735] <= 8'h00;
      mem[737] <= 8'h00;
      mem_ready <= 1'b1;
    end else begin
      if (ram_write == HIVE_WR) mem[ram_addr] <= ram_data;
      ram_dout <= mem[ram_addr];
    end
  end

  // Monitor: compares every RAM write and every done pulse against the queues
  always @(negedge clk_pix) begin
    if (rst_n) begin
      if (ram_write == HIVE_WR) begin
        n_chk++;
        if (exp_wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_addr got=%0d expected=no write", ram_addr);
        end else begin
          ea = exp_wr_q.pop_front();
          if (int'(ram_addr) != ea) begin
            n_fail++;
            $display("FAIL wr_addr got=%0d expected=%0d", ram_addr, ea);
          end
        end
        n_chk++;
        if (ram_data !== BG_IDX) begin
          n_fail++;
          $display("FAIL wr_data got=%0h expected=%0h", ram_data, BG_IDX);
        end
      end
      if (ram_addr == 12'd1999) cnt1999++;
      if (done === 1'b1) begin
        done_cnt++;
        n_chk++;
        if (exp_done_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected solid_cnt=%0d expected=no done", solid_cnt);
        end else begin
          ed = exp_done_q.pop_front();
          if (solid_cnt !== 6'(ed.cnt)) begin
            n_fail++;
            $display("FAIL solid_cnt got=%0d expected=%0d", solid_cnt, ed.cnt);
          end
          if (ed.lat >= 0) begin
            n_chk++;
            if (cyc - last_hit_cyc != ed.lat) begin
              n_fail++;
              $display("FAIL done_latency got=%0d expected=%0d", cyc - last_hit_cyc, ed.lat);
            end
          end
          $display("crater done: solid_cnt=%0d expected=%0d", solid_cnt, ed.cnt);
        end
        n_chk++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_at_done got=%0b expected=0", busy);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic issue_hit(input int x, input int y, input bit record);
    @(posedge clk_pix); #1;
    hit_x   = 7'(x);
    hit_y   = 6'(y);
    hit_req = 1'b1;
    if (record) last_hit_cyc = cyc;
    @(posedge clk_pix); #1;
    hit_req = 1'b0;
  endtask

  // Queue the writes held in wtab plus the crater result
  task automatic expect_crater(input int cnt, input int lat);
    exp_done_t e;
    foreach (wtab[i]) exp_wr_q.push_back(wtab[i]);
    e.cnt = cnt;
    e.lat = lat;
    exp_done_q.push_back(e);
  endtask

  task automatic wait_done(input int limit);
    int start_cnt;
    int k;
    start_cnt = done_cnt;
    k = 0;
    while (done_cnt == start_cnt && k < limit) begin
      @(posedge clk_pix);
      k++;
    end
    #1;
    n_chk++;
    if (done_cnt == start_cnt) begin
      n_fail++;
      $display("FAIL done_timeout got=no done after %0d cycles expected=done", k);
    end
    repeat (2) @(posedge clk_pix);
    #1;
  endtask

  initial begin
    int k;
    int t4_addr[9];
    logic [7:0] t4_exp[9];
    logic [7:0] m;

    // Reset state
    disp_addr = 12'd123;
    repeat (3) @(posedge clk_pix);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_solid_cnt", 32'(solid_cnt), 32'd0);
    check("rst_ram_write", 32'(ram_write), 32'(HIVE_RD));
    check("rst_ram_addr", 32'(ram_addr), 32'd123);
    @(negedge clk_pix);
    rst_n = 1'b1;
    disp_addr = 12'd0;
    repeat (2) @(posedge clk_pix);

    // Centre hit (33,19)
    if (RAGGED != 0) begin
      wtab = '{1221, 1286, 1287, 1288, 1353};
      expect_crater(5, 30);
    end else begin
      wtab = '{1220, 1221, 1222, 1286, 1287, 1288, 1352, 1353, 1354};
      expect_crater(9, 38);
    end
    issue_hit(33, 19, 1'b1);
    check("busy_after_hit", 32'(busy), 32'd1);
    wait_done(200);

    // Corner clip (0,0)
    if (RAGGED != 0) begin
      wtab = '{0, 1, 66};
      expect_crater(3, 26);
    end else begin
      wtab = '{0, 1, 66, 67};
      expect_crater(4, 28);
    end
    issue_hit(0, 0, 1'b1);
    wait_done(200);

    // Mixed content at (10,10), then the identical hit again
    wtab = '{604, 669, 671, 736};
    expect_crater(4, (RAGGED != 0) ? 29 : 33);
    issue_hit(10, 10, 1'b1);
    wait_done(200);
    wtab = '{};
    expect_crater(0, (RAGGED != 0) ? 25 : 29);
    issue_hit(10, 10, 1'b1);
    wait_done(200);

    // Blank toggling at (20,30): drop blank during CHK of cell 3 (address 1999)
    t4_addr = '{1933, 1934, 1935, 1999, 2000, 2001, 2065, 2066, 2067};
    if (RAGGED != 0) begin
      wtab = '{1934, 1999, 2000, 2001, 2066};
      expect_crater(5, -1);
      t4_exp = '{8'h5A, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h5A};
    end else begin
      wtab = '{1933, 1934, 1935, 1999, 2000, 2001, 2065, 2066, 2067};
      expect_crater(9, -1);
      t4_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    end
    cnt1999 = 0;
    issue_hit(20, 30, 1'b1);
    k = 0;
    while (ram_addr != 12'd1999 && k < 100) begin
      @(negedge clk_pix);
      k++;
    end
    check("cell3_read_seen", 32'(ram_addr == 12'd1999), 32'd1);
    @(posedge clk_pix); #1;
    blank = 1'b0;
    disp_addr = 12'd2000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_pix);
      check("nblank_mux", {19'd0, ram_write, ram_addr == 12'd2000, ram_addr}, {19'd0, HIVE_RD, 1'b1, 12'd2000});
    end
    @(posedge clk_pix); #1;
    blank = 1'b1;
    disp_addr = 12'd0;
    wait_done(200);
    check("cell3_addr_cycles", 32'(cnt1999), 32'd4);
    for (int i = 0; i < 9; i++) begin
      m = mem[t4_addr[i]];
      check("blank_image", 32'(m), 32'(t4_exp[i]));
    end

    // Busy drop: second request at (50,5) while busy is ignored
    if (RAGGED != 0) begin
      wtab = '{269, 334, 335, 336, 401};
      expect_crater(5, 30);
    end else begin
      wtab = '{268, 269, 270, 334, 335, 336, 400, 401, 402};
      expect_crater(9, 38);
    end
    issue_hit(5, 5, 1'b1);
    repeat (4) @(posedge clk_pix);
    #1;
    check("busy_before_drop", 32'(busy), 32'd1);
    issue_hit(50, 5, 1'b0);
    wait_done(200);
    k = done_cnt;
    repeat (60) @(posedge clk_pix);
    #1;
    check("dropped_no_done", 32'(done_cnt), 32'(k));
    m = mem[380];
    check("dropped_no_write", 32'(m), 32'h5A);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);

    // Reset mid-crater at (40,20)
    if (RAGGED != 0) begin
      wtab = '{1294, 1359, 1360, 1361, 1426};
      expect_crater(5, -1);
    end else begin
      wtab = '{1293, 1294, 1295, 1359, 1360, 1361, 1425, 1426, 1427};
      expect_crater(9, -1);
    end
    issue_hit(40, 20, 1'b1);
    repeat (12) @(posedge clk_pix);
    #5;
    check("busy_mid_crater", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_solid_cnt", 32'(solid_cnt), 32'd0);
    exp_wr_q.delete();
    exp_done_q.delete();
    @(negedge clk_pix);
    rst_n = 1'b1;
    k = done_cnt;
    repeat (60) @(posedge clk_pix);
    #1;
    check("aborted_no_done", 32'(done_cnt), 32'(k));
    m = mem[(RAGGED != 0) ? 1294 : 1293];
    check("partial_first_erased", 32'(m), 32'h00);
    m = mem[(RAGGED != 0) ? 1426 : 1427];
    check("partial_last_intact", 32'(m), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
